ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline; the consumer of the decode stage's `id_to_ex_bus`. Registers that bus under the shared stall vector, computes the ALU result from the operand selects, issues the data-SRAM request, and drives `ex_to_mem_bus`. Bits [37:0] of `ex_to_mem_bus` double as the forwarding path back to decode. An optional iterative multiplier with HI/LO registers holds the pipeline through `stallreq`.

---
 rtl/ex_stage.sv | 155 +++++++++++++++
 tb/tb_ex_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the five-stage MIPS pipeline: ALU, data-SRAM request and EX->MEM bus.
// Define EX_MUL_EN to build the iterative multiplier with HI/LO and mfhi/mflo.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq
);
    localparam int unsigned ID_TO_EX_WD = 159;
    localparam int unsigned DATA_W      = 32;
    localparam logic        STOP        = 1'b1;
    localparam logic        NO_STOP     = 1'b0;

    logic [ID_TO_EX_WD-1:0] ex_r;

    logic [DATA_W-1:0] pc, inst, rs_data, rt_data;
    logic [11:0]       alu_op;
    logic [2:0]        sel_src1;
    logic [3:0]        sel_src2;
    logic              ram_en, rf_we, sel_rf_res;
    logic [3:0]        ram_wen;
    logic [4:0]        rf_waddr;

    logic op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic op_or, op_xor, op_sll, op_srl, op_sra, op_lui;

    logic [DATA_W-1:0] src1, src2, add_res, alu_res, ex_result;

    // Pipeline register: bubble when EX stops but MEM runs, hold when both stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r <= '0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex_r <= '0;
        end else if (stall[2] == NO_STOP) begin
            ex_r <= id_to_ex_bus;
        end
    end

    assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rs_data, rt_data} = ex_r;

    assign {op_add, op_sub, op_slt, op_sltu, op_and, op_nor,
            op_or, op_xor, op_sll, op_srl, op_sra, op_lui} = alu_op;

    assign src1 = ({DATA_W{sel_src1[0]}} & rs_data)
                | ({DATA_W{sel_src1[1]}} & pc)
                | ({DATA_W{sel_src1[2]}} & {27'd0, inst[10:6]});

    assign src2 = ({DATA_W{sel_src2[0]}} & rt_data)
                | ({DATA_W{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({DATA_W{sel_src2[2]}} & 32'd8)
                | ({DATA_W{sel_src2[3]}} & {16'd0, inst[15:0]});

    assign add_res = src1 + src2;

    assign alu_res = ({DATA_W{op_add}}  & add_res)
                   | ({DATA_W{op_sub}}  & (src1 - src2))
                   | ({DATA_W{op_slt}}  & {31'd0, $signed(src1) < $signed(src2)})
                   | ({DATA_W{op_sltu}} & {31'd0, src1 < src2})
                   | ({DATA_W{op_and}}  & (src1 & src2))
                   | ({DATA_W{op_nor}}  & ~(src1 | src2))
                   | ({DATA_W{op_or}}   & (src1 | src2))
                   | ({DATA_W{op_xor}}  & (src1 ^ src2))
                   | ({DATA_W{op_sll}}  & (src2 << src1[4:0]))
                   | ({DATA_W{op_srl}}  & (src2 >> src1[4:0]))
                   | ({DATA_W{op_sra}}  & 32'($signed(src2) >>> src1[4:0]))
                   | ({DATA_W{op_lui}}  & {src2[15:0], 16'd0});

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t        mul_state;
    logic [4:0]        mul_cnt;
    logic [63:0]       mul_mcand, mul_prod, mul_prod_next;
    logic [DATA_W-1:0] mul_mplr, hi, lo, mag_rs, mag_rt;
    logic              mul_neg;
    logic              is_r_type, is_mult, is_multu, is_mfhi, is_mflo, mul_start;

    assign is_r_type = (inst[31:26] == 6'd0);
    assign is_mult   = is_r_type && (inst[5:0] == 6'b011000);
    assign is_multu  = is_r_type && (inst[5:0] == 6'b011001);
    assign is_mfhi   = is_r_type && (inst[5:0] == 6'b010000);
    assign is_mflo   = is_r_type && (inst[5:0] == 6'b010010);
    assign mul_start = is_mult || is_multu;

    assign mag_rs = (is_mult && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign mag_rt = (is_mult && rt_data[31]) ? (32'd0 - rt_data) : rt_data;

    assign mul_prod_next = mul_prod + (mul_mplr[0] ? mul_mcand : 64'd0);

    // Unsigned shift-add on magnitudes; sign applied when HI/LO are written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_state <= IDLE;
            mul_cnt   <= '0;
            mul_mcand <= '0;
            mul_mplr  <= '0;
            mul_prod  <= '0;
            mul_neg   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (mul_state)
                IDLE: begin
                    if (mul_start) begin
                        mul_mcand <= {32'd0, mag_rs};
                        mul_mplr  <= mag_rt;
                        mul_prod  <= '0;
                        mul_neg   <= is_mult && (rs_data[31] ^ rt_data[31]);
                        mul_cnt   <= '0;
                        mul_state <= BUSY;
                    end
                end
                BUSY: begin
                    mul_prod  <= mul_prod_next;
                    mul_mcand <= mul_mcand << 1;
                    mul_mplr  <= mul_mplr >> 1;
                    mul_cnt   <= mul_cnt + 5'd1;
                    if (mul_cnt == 5'd31) begin
                        {hi, lo}  <= mul_neg ? (64'd0 - mul_prod_next) : mul_prod_next;
                        mul_state <= DONE;
                    end
                end
                DONE:    mul_state <= IDLE;
                default: mul_state <= IDLE;
            endcase
        end
    end

    // DONE keeps the still-resident mult from retriggering while the pipe advances.
    assign stallreq  = (mul_state == BUSY) || (mul_state == IDLE && mul_start);
    assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);
`else
    assign stallreq  = 1'b0;
    assign ex_result = alu_res;
`endif

    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = add_res;
    assign data_sram_wdata = rt_data;

    assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};

    logic unused_ok;
    assign unused_ok = &{1'b0, stall[5:4], stall[1:0], inst};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed and random ALU, stall vector, multiplier and reset.
module tb_ex_stage;
    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SLT  = 12'h200;
    localparam logic [11:0] OP_SLTU = 12'h100;
    localparam logic [11:0] OP_SRA  = 12'h002;
    localparam logic [11:0] OP_LUI  = 12'h001;

    typedef struct packed {
        logic [75:0] bus;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [5:0]   tb_stall = 6'd0;
    logic         auto_hold = 1'b1;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus = '0;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq;

    int          total = 0;
    int          bad = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    // Stand-in for the hazard unit: EX's stall request holds IF..EX.
    assign stall = auto_hold ? (tb_stall | (stallreq ? 6'b001111 : 6'b000000)) : tb_stall;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq        (stallreq)
    );

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ren,
                                        input logic [3:0] rwen, input logic rfwe,
                                        input logic [4:0] wa, input logic rfres,
                                        input logic [31:0] rs, input logic [31:0] rt);
        return {pc, inst, op, s1, s2, ren, rwen, rfwe, wa, rfres, rs, rt};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        return {6'd0, 5'd4, 5'd5, 5'd9, 5'd0, funct};
    endfunction

    // Reference: what EX should present for the instruction word w.
    function automatic exp_t model(input logic [158:0] w);
        exp_t        e;
        logic [31:0] pc, inst, rs, rt, a, b, r;
        logic [11:0] op;
        pc = w[158:127]; inst = w[126:95]; op = w[94:83]; rs = w[63:32]; rt = w[31:0];
        case (w[82:80])
            3'b001:  a = rs;
            3'b010:  a = pc;
            3'b100:  a = {27'd0, inst[10:6]};
            default: a = 32'd0;
        endcase
        case (w[79:76])
            4'b0001: b = rt;
            4'b0010: b = {{16{inst[15]}}, inst[15:0]};
            4'b0100: b = 32'd8;
            4'b1000: b = {16'd0, inst[15:0]};
            default: b = 32'd0;
        endcase
        r = 32'd0;
        if (op[11]) r |= a + b;
        if (op[10]) r |= a - b;
        if (op[9])  r |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op[8])  r |= (a < b) ? 32'd1 : 32'd0;
        if (op[7])  r |= a & b;
        if (op[6])  r |= ~(a | b);
        if (op[5])  r |= a | b;
        if (op[4])  r |= a ^ b;
        if (op[3])  r |= b << a[4:0];
        if (op[2])  r |= b >> a[4:0];
        if (op[1])  r |= 32'($signed(b) >>> a[4:0]);
        if (op[0])  r |= {b[15:0], 16'd0};
`ifdef EX_MUL_EN
        if (inst[31:26] == 6'd0 && inst[5:0] == 6'b010000) r = hi_m;
        if (inst[31:26] == 6'd0 && inst[5:0] == 6'b010010) r = lo_m;
`endif
        e.bus   = {pc, w[75], w[74:71], w[64], w[70], w[69:65], r};
        e.en    = w[75];
        e.wen   = w[74:71];
        e.addr  = a + b;
        e.wdata = rt;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [158:0] w);
        exp_t e;
        e = model(w);
        chk({tag, "_bus"},   ex_to_mem_bus, e.bus);
        chk({tag, "_en"},    76'(data_sram_en), 76'(e.en));
        chk({tag, "_wen"},   76'(data_sram_wen), 76'(e.wen));
        chk({tag, "_addr"},  76'(data_sram_addr), 76'(e.addr));
        chk({tag, "_wdata"}, 76'(data_sram_wdata), 76'(e.wdata));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [158:0] w);
        id_to_ex_bus = w;
        step();
    endtask

`ifdef EX_MUL_EN
    // Issue mult/multu, count stall cycles, then read back via mflo and mfhi.
    task automatic run_mul(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int bub_at);
        int           n;
        logic [63:0]  p;
        logic [158:0] wm, wlo, whi;
        wm  = mk(32'h0040_0100, rtype(sgn ? 6'b011000 : 6'b011001), 12'h000, 3'b001, 4'b0001,
                 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, a, b);
        wlo = mk(32'h0040_0104, rtype(6'b010010), 12'($urandom), 3'b001, 4'b0001,
                 1'b0, 4'd0, 1'b1, 5'd8, 1'b0, $urandom, $urandom);
        whi = mk(32'h0040_0108, rtype(6'b010000), 12'($urandom), 3'b010, 4'b0001,
                 1'b0, 4'd0, 1'b1, 5'd9, 1'b0, $urandom, $urandom);
        load(wm);
        id_to_ex_bus = wlo;
        n = 0;
        while (stallreq === 1'b1 && n < 100) begin
            if (n == bub_at) begin
                auto_hold = 1'b0;
                tb_stall  = 6'b000100;
            end
            step();
            auto_hold = 1'b1;
            tb_stall  = 6'd0;
            n++;
        end
        chk({tag, "_stallcycles"}, 76'(n), 76'd33);
        if (sgn) p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        else     p = {32'd0, a} * {32'd0, b};
        {hi_m, lo_m} = p;
        step();
        chk({tag, "_stallreq_after"}, 76'(stallreq), 76'd0);
        check_out({tag, "_mflo"}, wlo);
        load(whi);
        check_out({tag, "_mfhi"}, whi);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [158:0] wa, wb, w;
        logic [11:0]  op;
        logic [2:0]   s1;
        logic [3:0]   s2;
        int           k;

        // Asynchronous reset forces all outputs to zero.
        id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
        #2 rst = 1'b1;
        #1;
        chk("rst_async_bus", ex_to_mem_bus, 76'd0);
        chk("rst_async_stallreq", 76'(stallreq), 76'd0);
        step();
        chk("rst_held_bus", ex_to_mem_bus, 76'd0);
        chk("rst_held_en", 76'(data_sram_en), 76'd0);
        chk("rst_held_addr", 76'(data_sram_addr), 76'd0);
        rst = 1'b0;

        // addiu $2, $1, -1
        w = mk(32'hBFC0_0000, {6'b001001, 5'd1, 5'd2, 16'hFFFF}, OP_ADD, 3'b001, 4'b0010,
               1'b0, 4'd0, 1'b1, 5'd2, 1'b0, 32'h0000_0010, 32'h1234_5678);
        load(w);
        check_out("addiu", w);
        chk("addiu_res", 76'(ex_to_mem_bus[31:0]), 76'h0000_000F);
        chk("addiu_fwd_we", 76'(ex_to_mem_bus[37]), 76'd1);
        chk("addiu_fwd_waddr", 76'(ex_to_mem_bus[36:32]), 76'd2);

        w = mk(32'hBFC0_0004, {6'b001111, 5'd0, 5'd3, 16'h1234}, OP_LUI, 3'b000, 4'b1000,
               1'b0, 4'd0, 1'b1, 5'd3, 1'b0, 32'hDEAD_BEEF, 32'h0);
        load(w);
        check_out("lui", w);
        chk("lui_res", 76'(ex_to_mem_bus[31:0]), 76'h1234_0000);

        w = mk(32'hBFC0_0008, {6'd0, 5'd0, 5'd4, 5'd5, 5'd4, 6'b000011}, OP_SRA, 3'b100, 4'b0001,
               1'b0, 4'd0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h8000_0000);
        load(w);
        check_out("sra", w);
        chk("sra_res", 76'(ex_to_mem_bus[31:0]), 76'hF800_0000);

        w = mk(32'hBFC0_000C, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101010}, OP_SLT, 3'b001, 4'b0001,
               1'b0, 4'd0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'h1);
        load(w);
        chk("slt_res", 76'(ex_to_mem_bus[31:0]), 76'd1);
        w[94:83] = OP_SLTU;
        load(w);
        chk("sltu_res", 76'(ex_to_mem_bus[31:0]), 76'd0);

        // sw: address from base+offset, store data from rt.
        wa = mk(32'hBFC0_0010, {6'b101011, 5'd1, 5'd2, 16'hFFF8}, OP_ADD, 3'b001, 4'b0010,
                1'b1, 4'b1111, 1'b1, 5'd7, 1'b1, 32'h8000_1000, 32'hCAFE_F00D);
        load(wa);
        check_out("sw", wa);

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(3, 0);
            s1 = (k == 0) ? 3'd0 : 3'(1 << (k - 1));
            k  = $urandom_range(4, 0);
            s2 = (k == 0) ? 4'd0 : 4'(1 << (k - 1));
            k  = $urandom_range(13, 0);
            if (k < 12)       op = 12'(1 << k);
            else if (k == 12) op = 12'd0;
            else              op = 12'(1 << $urandom_range(11, 0)) | 12'(1 << $urandom_range(11, 0));
            w = mk($urandom, $urandom | 32'h8000_0000, op, s1, s2, 1'($urandom), 4'($urandom),
                   1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom);
            load(w);
            check_out("rand_alu", w);
        end

        // Stall vector: bubble, hold, and stall[3] alone not blocking a load.
        wb = mk(32'hBFC0_0020, 32'h8C22_0004, OP_ADD, 3'b001, 4'b0010,
                1'b1, 4'b0000, 1'b1, 5'd2, 1'b1, 32'h0000_2000, 32'h5555_AAAA);
        load(wa);
        id_to_ex_bus = wb;
        tb_stall = 6'b000100;
        step();
        chk("bubble_bus", ex_to_mem_bus, 76'd0);
        chk("bubble_rf_we", 76'(ex_to_mem_bus[37]), 76'd0);
        chk("bubble_sram_en", 76'(data_sram_en), 76'd0);
        tb_stall = 6'd0;
        load(wa);
        id_to_ex_bus = wb;
        tb_stall = 6'b001100;
        step();
        step();
        check_out("hold", wa);
        tb_stall = 6'b001000;
        step();
        check_out("stall3_only_loads", wb);
        tb_stall = 6'd0;

`ifdef EX_MUL_EN
        run_mul("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, -1);
        chk("mult_m3x5_hi", 76'(ex_to_mem_bus[31:0]), 76'hFFFF_FFFF);
        run_mul("multu_max_x2", 1'b0, 32'hFFFF_FFFF, 32'd2, -1);
        chk("multu_max_x2_hi", 76'(ex_to_mem_bus[31:0]), 76'd1);
        run_mul("mult_bubble_busy", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 5);
        for (int i = 0; i < 4; i++) begin
            run_mul("rand_mul", 1'($urandom), $urandom, $urandom, -1);
        end

        // Reset during BUSY cycle 10, then a fresh multiply.
        w = mk(32'h0040_0200, rtype(6'b011000), 12'h000, 3'b001, 4'b0001,
               1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'h0000_1234, 32'hFFFF_0000);
        load(w);
        for (int i = 0; i < 9; i++) step();
        chk("midrst_busy_stallreq", 76'(stallreq), 76'd1);
        rst = 1'b1;
        #1;
        chk("midrst_stallreq", 76'(stallreq), 76'd0);
        chk("midrst_bus", ex_to_mem_bus, 76'd0);
        hi_m = '0;
        lo_m = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        w = mk(32'h0040_0300, rtype(6'b010000), OP_ADD, 3'b001, 4'b0001,
               1'b0, 4'd0, 1'b1, 5'd9, 1'b0, $urandom, $urandom);
        load(w);
        check_out("midrst_mfhi", w);
        w[126:95] = rtype(6'b010010);
        load(w);
        check_out("midrst_mflo", w);
        run_mul("mult_after_rst", 1'b1, 32'h0000_1234, 32'hFFFF_0000, -1);
`else
        // Without the multiplier, mult and mfhi are plain ALU instructions.
        w = mk(32'h0040_0100, rtype(6'b011000), 12'h000, 3'b001, 4'b0001,
               1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'hFFFF_FFFD, 32'd5);
        load(w);
        chk("nomul_stallreq", 76'(stallreq), 76'd0);
        check_out("nomul_mult", w);
        step();
        chk("nomul_stallreq_next", 76'(stallreq), 76'd0);
        w = mk(32'h0040_0104, rtype(6'b010000), OP_ADD, 3'b001, 4'b0001,
               1'b0, 4'd0, 1'b1, 5'd9, 1'b0, 32'd7, 32'd9);
        load(w);
        check_out("nomul_mfhi", w);
        chk("nomul_mfhi_res", 76'(ex_to_mem_bus[31:0]), 76'd16);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
